// File: rtl/control_fsm_pkg.sv
// Shared ISA definitions for the CR16-subset control unit: opcode/opext
// constants, condition codes, state encoding, mux encodings and the
// per-state control word decode.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_LATCH   = 4'd1,
    ST_ALU_WB  = 4'd2,
    ST_LD_ADDR = 4'd3,
    ST_LD_WB   = 4'd4,
    ST_ST_WR   = 4'd5,
    ST_BR      = 4'd6,
    ST_JMP     = 4'd7,
    ST_JAL     = 4'd8
  } state_e;

  // Major opcodes (IR[15:12])
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADDI    = 4'b0101;
  localparam logic [3:0] OP_SUBI    = 4'b1001;
  localparam logic [3:0] OP_CMPI    = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOVI    = 4'b1101;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // Register-register opcode extensions (IR[7:4] when opcode is 0000)
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  // Opcode extensions under opcode 0100
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Condition codes (IR[11:8])
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  // Flag bit positions in {N,Z,F,L,C}
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  // Write-data and ALU-A mux encodings
  localparam logic [1:0] WD_MEM     = 2'b00;
  localparam logic [1:0] WD_PC      = 2'b01;
  localparam logic [1:0] WD_ALU     = 2'b11;
  localparam logic [1:0] ALUA_RDEST = 2'b00;
  localparam logic [1:0] ALUA_PC    = 2'b01;

  // One registered control word; cond_en marks states whose pcen follows cond_true
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] opext;
    logic [7:0] imm;
    logic       wa_s;
    logic       pc_s;
    logic       alub_s;
    logic       mem_s;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic       signext_sign;
    logic       pcen;
    logic       regwrite;
    logic       memwrite;
    logic       flagwrite;
    logic       cond_en;
  } ctrl_t;

  function automatic logic is_alu_ext(input logic [3:0] ext);
    case (ext)
      EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_SUB, EXT_CMP, EXT_MOV: is_alu_ext = 1'b1;
      default: is_alu_ext = 1'b0;
    endcase
  endfunction

  function automatic logic is_imm_op(input logic [3:0] op);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI, OP_LUI: is_imm_op = 1'b1;
      default: is_imm_op = 1'b0;
    endcase
  endfunction

  // Instruction class -> first execute state (FETCH means treated as NOP)
  function automatic state_e decode_next(input logic [15:0] ir);
    logic [3:0] op;
    logic [3:0] ext;
    op  = ir[15:12];
    ext = ir[7:4];
    decode_next = ST_FETCH;
    if (op == OP_RTYPE) begin
      decode_next = is_alu_ext(ext) ? ST_ALU_WB : ST_FETCH;
    end else if (is_imm_op(op)) begin
      decode_next = ST_ALU_WB;
    end else if (op == OP_BCOND) begin
      decode_next = ST_BR;
    end else if (op == OP_SPECIAL) begin
      case (ext)
        EXT_LOAD:  decode_next = ST_LD_ADDR;
        EXT_STOR:  decode_next = ST_ST_WR;
        EXT_JAL:   decode_next = ST_JAL;
        EXT_JCOND: decode_next = ST_JMP;
        default:   decode_next = ST_FETCH;
      endcase
    end else begin
      decode_next = ST_FETCH;
    end
  endfunction

  // Control word presented while in state st with instruction register ir
  function automatic ctrl_t ctrl_for(input state_e st, input logic [15:0] ir);
    logic [3:0] op;
    logic [3:0] ext;
    op  = ir[15:12];
    ext = ir[7:4];
    ctrl_for     = '0;
    ctrl_for.imm = ir[7:0];
    case (st)
      ST_FETCH: begin
        // PC <= PC + 1 through the ALU; independent of IR
        ctrl_for.alua_s = ALUA_PC;
        ctrl_for.alub_s = 1'b1;
        ctrl_for.imm    = 8'h01;
        ctrl_for.opcode = OP_ADDI;
        ctrl_for.opext  = 4'b0000;
        ctrl_for.pcen   = 1'b1;
      end
      ST_LATCH: begin
        ctrl_for.imm = ir[7:0];
      end
      ST_ALU_WB: begin
        ctrl_for.alua_s = ALUA_RDEST;
        ctrl_for.opcode = op;
        ctrl_for.opext  = ext;
        ctrl_for.alub_s = (op != OP_RTYPE);
        ctrl_for.signext_sign = (op == OP_ADDI) || (op == OP_SUBI) ||
                                (op == OP_CMPI) || (op == OP_MOVI);
        ctrl_for.wd_s = WD_ALU;
        ctrl_for.wa_s = 1'b1;
        if (op == OP_RTYPE) begin
          ctrl_for.regwrite  = (ext != EXT_CMP);
          ctrl_for.flagwrite = (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
        end else begin
          ctrl_for.regwrite  = (op != OP_CMPI);
          ctrl_for.flagwrite = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
        end
      end
      ST_LD_ADDR: begin
        ctrl_for.mem_s = 1'b1;
      end
      ST_LD_WB: begin
        ctrl_for.wd_s     = WD_MEM;
        ctrl_for.wa_s     = 1'b1;
        ctrl_for.regwrite = 1'b1;
      end
      ST_ST_WR: begin
        ctrl_for.mem_s    = 1'b1;
        ctrl_for.memwrite = 1'b1;
      end
      ST_BR: begin
        // PC already holds Bcond address + 1; add sign-extended displacement
        ctrl_for.alua_s       = ALUA_PC;
        ctrl_for.alub_s       = 1'b1;
        ctrl_for.imm          = ir[7:0];
        ctrl_for.signext_sign = 1'b1;
        ctrl_for.opcode       = OP_ADDI;
        ctrl_for.opext        = 4'b0000;
        ctrl_for.cond_en      = 1'b1;
      end
      ST_JMP: begin
        ctrl_for.pc_s    = 1'b1;
        ctrl_for.cond_en = 1'b1;
      end
      ST_JAL: begin
        // PC already holds the return address: link and jump in one cycle
        ctrl_for.wd_s     = WD_PC;
        ctrl_for.wa_s     = 1'b1;
        ctrl_for.regwrite = 1'b1;
        ctrl_for.pc_s     = 1'b1;
        ctrl_for.pcen     = 1'b1;
      end
      default: begin
        ctrl_for = '0;
      end
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control-unit bus: memory read data and flags in, datapath/alucontrol
// control signals out.
interface control_fsm_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic [WIDTH-1:0]   mem_out;
  logic [4:0]         flags;
  logic [3:0]         opcode;
  logic [3:0]         opext;
  logic [REGBITS-1:0] rdest_idx;
  logic [REGBITS-1:0] rsrc_idx;
  logic [7:0]         imm;
  logic               wa_s;
  logic               pc_s;
  logic               alub_s;
  logic               mem_s;
  logic [1:0]         wd_s;
  logic [1:0]         alua_s;
  logic               signext_sign;
  logic               pcen;
  logic               regwrite;
  logic               memwrite;
  logic               flagwrite;

  modport master (
    input  mem_out, flags,
    output opcode, opext, rdest_idx, rsrc_idx, imm, wa_s, pc_s, alub_s, mem_s,
           wd_s, alua_s, signext_sign, pcen, regwrite, memwrite, flagwrite
  );

  modport slave (
    output mem_out, flags,
    input  opcode, opext, rdest_idx, rsrc_idx, imm, wa_s, pc_s, alub_s, mem_s,
           wd_s, alua_s, signext_sign, pcen, regwrite, memwrite, flagwrite
  );
endinterface

// File: rtl/control_fsm_cond_check.sv
// Branch/jump condition evaluation against the {N,Z,F,L,C} flag register.
module cond_check
  import control_fsm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       cond_true
);

  logic n_s, z_s, f_s, l_s, c_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign f_s = flags[FLAG_F];
  assign l_s = flags[FLAG_L];
  assign c_s = flags[FLAG_C];

  // Map condition code to a single taken/not-taken bit
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_EQ:   cond_true = z_s;
      CC_NE:   cond_true = !z_s;
      CC_CS:   cond_true = c_s;
      CC_CC:   cond_true = !c_s;
      CC_HI:   cond_true = l_s;
      CC_LS:   cond_true = !l_s;
      CC_GT:   cond_true = n_s;
      CC_LE:   cond_true = !n_s;
      CC_FS:   cond_true = f_s;
      CC_FC:   cond_true = !f_s;
      CC_LO:   cond_true = !l_s && !z_s;
      CC_HS:   cond_true = l_s || z_s;
      CC_LT:   cond_true = !n_s && !z_s;
      CC_GE:   cond_true = n_s || z_s;
      CC_UC:   cond_true = 1'b1;
      CC_NV:   cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the CR16-subset CPU: fetch, latch/decode,
// execute/writeback sequencing with a registered control word.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic          clk50MHz,
  input  logic          reset,
  control_fsm_if.master bus
);

  state_e           state_r;
  logic [WIDTH-1:0] ir_r;
  ctrl_t            ctrl_r;
  ctrl_t            out_s;
  state_e           latch_next_s;
  logic             cond_true_s;

  // Decode of the word being latched decides the first execute state
  assign latch_next_s = decode_next(bus.mem_out[15:0]);

  cond_check u_cond_check (
    .cond      (ir_r[11:8]),
    .flags     (bus.flags),
    .cond_true (cond_true_s)
  );

  // State, IR and next-state control word; synchronous active-low reset
  always_ff @(posedge clk50MHz) begin
    if (!reset) begin
      state_r <= ST_FETCH;
      ir_r    <= '0;
      ctrl_r  <= ctrl_for(ST_FETCH, 16'h0000);
    end else begin
      case (state_r)
        ST_FETCH: begin
          state_r <= ST_LATCH;
          ctrl_r  <= ctrl_for(ST_LATCH, ir_r[15:0]);
        end
        ST_LATCH: begin
          ir_r    <= bus.mem_out;
          state_r <= latch_next_s;
          ctrl_r  <= ctrl_for(latch_next_s, bus.mem_out[15:0]);
        end
        ST_LD_ADDR: begin
          state_r <= ST_LD_WB;
          ctrl_r  <= ctrl_for(ST_LD_WB, ir_r[15:0]);
        end
        default: begin
          state_r <= ST_FETCH;
          ctrl_r  <= ctrl_for(ST_FETCH, ir_r[15:0]);
        end
      endcase
    end
  end

  // Hold every select and enable at zero while reset is asserted
  always_comb begin
    if (reset) begin
      out_s = ctrl_r;
    end else begin
      out_s = '0;
    end
  end

  assign bus.opcode       = out_s.opcode;
  assign bus.opext        = out_s.opext;
  assign bus.imm          = out_s.imm;
  assign bus.wa_s         = out_s.wa_s;
  assign bus.pc_s         = out_s.pc_s;
  assign bus.alub_s       = out_s.alub_s;
  assign bus.mem_s        = out_s.mem_s;
  assign bus.wd_s         = out_s.wd_s;
  assign bus.alua_s       = out_s.alua_s;
  assign bus.signext_sign = out_s.signext_sign;
  assign bus.regwrite     = out_s.regwrite;
  assign bus.memwrite     = out_s.memwrite;
  assign bus.flagwrite    = out_s.flagwrite;
  // Branch/jump enables follow the live flags in BR/JMP
  assign bus.pcen         = out_s.pcen | (out_s.cond_en & cond_true_s);
  assign bus.rdest_idx    = ir_r[8 +: REGBITS];
  assign bus.rsrc_idx     = ir_r[0 +: REGBITS];

endmodule

// File: tb/tb_control_fsm.sv
// Directed testbench for control_fsm with hand-computed expectations.
module tb_control_fsm;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  control_fsm_if #(.WIDTH(16), .REGBITS(4)) bus ();

  control_fsm #(.WIDTH(16), .REGBITS(4)) dut (
    .clk50MHz (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // {pcen, regwrite, memwrite, flagwrite}
  logic [3:0] en_s;
  assign en_s = {bus.pcen, bus.regwrite, bus.memwrite, bus.flagwrite};

  // {wa_s, pc_s, alub_s, mem_s, wd_s, alua_s, signext_sign}
  logic [8:0] sel_s;
  assign sel_s = {bus.wa_s, bus.pc_s, bus.alub_s, bus.mem_s, bus.wd_s, bus.alua_s, bus.signext_sign};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH now; presents instr and advances into the first execute state
  task automatic fetch_latch(input logic [15:0] instr);
    check("fetch_en", {12'h000, en_s}, 16'h0008);
    check("fetch_imm", {8'h00, bus.imm}, 16'h0001);
    bus.mem_out = instr;
    tick();
    check("latch_en", {12'h000, en_s}, 16'h0000);
    tick();
  endtask

  initial begin
    bus.mem_out = 16'h0000;
    bus.flags   = 5'b00000;

    // Reset held low for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_en", {12'h000, en_s}, 16'h0000);
      check("rst_sel", {7'h00, sel_s}, 16'h0000);
      check("rst_opimm", {bus.opcode, bus.opext, bus.imm}, 16'h0000);
    end

    // First cycle with reset high is FETCH; ADD R3,R5 on the memory bus
    reset = 1'b1;
    bus.mem_out = 16'h0355;
    #1;
    check("fetch0_en", {12'h000, en_s}, 16'h0008);
    check("fetch0_imm", {8'h00, bus.imm}, 16'h0001);
    // wa,pc,alub,mem,wd,alua,sext = 0,0,1,0,00,01,0
    check("fetch0_sel", {7'h00, sel_s}, 16'h0042);
    check("fetch0_op", {12'h000, bus.opcode}, 16'h0005);
    tick();
    check("add_latch_en", {12'h000, en_s}, 16'h0000);
    tick();
    check("add_en", {12'h000, en_s}, 16'h0005);
    check("add_op", {8'h00, bus.opcode, bus.opext}, 16'h0005);
    // wa=1,pc=0,alub=0,mem=0,wd=11,alua=00,sext=0
    check("add_sel", {7'h00, sel_s}, 16'h0118);
    check("add_idx", {8'h00, bus.rdest_idx, bus.rsrc_idx}, 16'h0035);
    tick();

    // LOAD R2,[R7]: 4-cycle latency
    fetch_latch(16'h4207);
    check("ld_addr_en", {12'h000, en_s}, 16'h0000);
    check("ld_addr_mem_s", {15'h0000, bus.mem_s}, 16'h0001);
    tick();
    check("ld_wb_en", {12'h000, en_s}, 16'h0004);
    // wa=1, wd=00
    check("ld_wb_sel", {7'h00, sel_s}, 16'h0100);
    check("ld_wb_idx", {8'h00, bus.rdest_idx, bus.rsrc_idx}, 16'h0027);
    tick();

    // CMPI R2,#-1: flags only, sign-extended immediate
    fetch_latch(16'hB2FF);
    check("cmpi_en", {12'h000, en_s}, 16'h0001);
    // wa=1,alub=1,wd=11,sext=1
    check("cmpi_sel", {7'h00, sel_s}, 16'h0159);
    check("cmpi_opimm", {bus.opcode, bus.opext, bus.imm}, 16'hBFFF);
    tick();

    // ANDI R10,#0x0F: zero-extended, no flags
    fetch_latch(16'h1A0F);
    check("andi_en", {12'h000, en_s}, 16'h0004);
    check("andi_sext", {15'h0000, bus.signext_sign}, 16'h0000);
    tick();

    // STOR R3,[R6]
    fetch_latch(16'h4346);
    check("stor_en", {12'h000, en_s}, 16'h0002);
    check("stor_mem_s", {15'h0000, bus.mem_s}, 16'h0001);
    tick();

    // Bcond EQ disp FE with Z=1: taken
    bus.flags = 5'b01000;
    fetch_latch(16'hC0FE);
    check("beq_t_en", {12'h000, en_s}, 16'h0008);
    check("beq_t_imm", {8'h00, bus.imm}, 16'h00FE);
    // alub=1, alua=01, sext=1, pc_s=0
    check("beq_t_sel", {7'h00, sel_s}, 16'h0043);
    check("beq_t_op", {12'h000, bus.opcode}, 16'h0005);
    tick();

    // Bcond EQ with Z=0: not taken; flags are sampled live in BR
    bus.flags = 5'b00000;
    fetch_latch(16'hC0FE);
    check("beq_nt_en", {12'h000, en_s}, 16'h0000);
    bus.flags = 5'b01000;
    #1;
    check("beq_live_en", {12'h000, en_s}, 16'h0008);
    tick();

    // Unconditional branch with disp 80
    bus.flags = 5'b00000;
    fetch_latch(16'hCE80);
    check("buc_en", {12'h000, en_s}, 16'h0008);
    check("buc_imm", {8'h00, bus.imm}, 16'h0080);
    tick();

    // Never-taken condition 1111
    fetch_latch(16'hCF05);
    check("bnv_en", {12'h000, en_s}, 16'h0000);
    tick();

    // Jcond LO: taken with L=0,Z=0, not taken once L=1
    fetch_latch(16'h4AC3);
    check("jlo_en", {12'h000, en_s}, 16'h0008);
    check("jlo_pc_s", {15'h0000, bus.pc_s}, 16'h0001);
    bus.flags = 5'b00010;
    #1;
    check("jlo_nt_en", {12'h000, en_s}, 16'h0000);
    tick();
    bus.flags = 5'b00000;

    // JAL R14,R9
    fetch_latch(16'h4E89);
    check("jal_en", {12'h000, en_s}, 16'h000C);
    // wa=1, pc=1, wd=01
    check("jal_sel", {7'h00, sel_s}, 16'h0188);
    check("jal_idx", {8'h00, bus.rdest_idx, bus.rsrc_idx}, 16'h00E9);
    tick();

    // NOPs: undefined opcode and undefined R-type opext, 2-cycle latency
    fetch_latch(16'h8000);
    check("nop1_fetch_en", {12'h000, en_s}, 16'h0008);
    fetch_latch(16'h0300);
    check("nop2_fetch_en", {12'h000, en_s}, 16'h0008);

    // Reset asserted during LD_ADDR aborts the load
    fetch_latch(16'h4207);
    check("abort_ld_mem_s", {15'h0000, bus.mem_s}, 16'h0001);
    reset = 1'b0;
    #1;
    check("abort_en", {12'h000, en_s}, 16'h0000);
    check("abort_sel", {7'h00, sel_s}, 16'h0000);
    tick();
    check("abort_next_en", {12'h000, en_s}, 16'h0000);
    check("abort_ir_clr", {8'h00, bus.rdest_idx, bus.rsrc_idx}, 16'h0000);
    reset = 1'b1;
    bus.mem_out = 16'h0355;
    #1;
    check("resume_fetch_en", {12'h000, en_s}, 16'h0008);
    check("resume_fetch_imm", {8'h00, bus.imm}, 16'h0001);
    tick();
    tick();
    check("resume_add_en", {12'h000, en_s}, 16'h0005);
    check("resume_add_idx", {8'h00, bus.rdest_idx, bus.rsrc_idx}, 16'h0035);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
